// File: rtl/mig_app_responder.sv
// MIG 7-series app-interface responder: command/write-data FIFOs, in-order
// executor over an internal RAM, fixed-latency read return, calibration delay
// and periodic refresh stalls. Stands in for the MIG core in simulation.
module mig_app_responder #(
  parameter int unsigned DATA_WIDTH   = 128,
  parameter int unsigned ADDR_WIDTH   = 28,
  parameter int unsigned MEM_AW       = 10,
  parameter int unsigned RD_LATENCY   = 8,
  parameter int unsigned CALIB_CYCLES = 64,
  parameter int unsigned REF_PERIOD   = 256,
  parameter int unsigned REF_STALL    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    app_en,
  input  logic [2:0]              app_cmd,
  input  logic [ADDR_WIDTH-1:0]   app_addr,
  output logic                    app_rdy,
  input  logic                    app_wdf_wren,
  input  logic                    app_wdf_end,
  input  logic [DATA_WIDTH-1:0]   app_wdf_data,
  input  logic [DATA_WIDTH/8-1:0] app_wdf_mask,
  output logic                    app_wdf_rdy,
  output logic [DATA_WIDTH-1:0]   app_rd_data,
  output logic                    app_rd_data_valid,
  output logic                    app_rd_data_end,
  output logic                    init_calib_complete,
  output logic                    err
);

  localparam int unsigned MASK_W    = DATA_WIDTH / 8;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned PTR_W     = 2;
  localparam int unsigned CNT_W     = 3;
  localparam int unsigned MEM_DEPTH = 1 << MEM_AW;
  localparam int unsigned CAL_W     = (CALIB_CYCLES > 0) ? $clog2(CALIB_CYCLES + 1) : 1;
  localparam int unsigned REF_W     = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam int unsigned REF_LAST  = (REF_PERIOD > 0) ? REF_PERIOD - 1 : 0;
  localparam int unsigned REF_ON    = (REF_PERIOD > REF_STALL) ? REF_PERIOD - REF_STALL : 0;
  localparam bit          STALL_EN  = (REF_PERIOD != 0) && (REF_STALL != 0);
  localparam logic [2:0]  CMD_WR    = 3'b000;
  localparam logic [2:0]  CMD_RD    = 3'b001;

  // FIFO storage (not reset; validity is tracked by pointers and counts)
  logic [2:0]            cmd_q  [DEPTH];
  logic [MEM_AW-1:0]     idx_q  [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [MASK_W-1:0]     mask_q [DEPTH];

  logic [PTR_W-1:0] cmd_wr, cmd_rd, wdf_wr, wdf_rd;
  logic [CNT_W-1:0] cmd_cnt, wdf_cnt;
  logic [CAL_W-1:0] cal_cnt;
  logic [REF_W-1:0] ref_cnt;
  logic             stall_q;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  rd_vld_pipe [RD_LATENCY];
  logic [DATA_WIDTH-1:0] rd_dat_pipe [RD_LATENCY];

  logic [2:0]        head_cmd_c;
  logic [MEM_AW-1:0] head_idx_c;
  logic              cmd_push_c, wdf_push_c;
  logic              exec_go_c, wr_go_c, rd_go_c, bad_go_c;
  logic [CNT_W-1:0]  cmd_cnt_c, wdf_cnt_c;
  logic [CAL_W-1:0]  cal_cnt_c;
  logic [REF_W-1:0]  ref_cnt_c;
  logic              calib_c, stall_c, app_rdy_c, app_wdf_rdy_c, err_c;

  logic unused_addr_c;
  assign unused_addr_c = ^app_addr[ADDR_WIDTH-1:MEM_AW+3];

  // Handshakes, executor decision, counters and next ready/err values
  always_comb begin
    head_cmd_c    = cmd_q[cmd_rd];
    head_idx_c    = idx_q[cmd_rd];
    cmd_push_c    = app_en && app_rdy;
    wdf_push_c    = app_wdf_wren && app_wdf_rdy;
    exec_go_c     = !stall_q && (cmd_cnt != '0) &&
                    ((head_cmd_c != CMD_WR) || (wdf_cnt != '0));
    wr_go_c       = exec_go_c && (head_cmd_c == CMD_WR);
    rd_go_c       = exec_go_c && (head_cmd_c == CMD_RD);
    bad_go_c      = exec_go_c && (head_cmd_c != CMD_WR) && (head_cmd_c != CMD_RD);
    cmd_cnt_c     = cmd_cnt + CNT_W'(cmd_push_c) - CNT_W'(exec_go_c);
    wdf_cnt_c     = wdf_cnt + CNT_W'(wdf_push_c) - CNT_W'(wr_go_c);

    cal_cnt_c     = cal_cnt;
    if (cal_cnt != CAL_W'(CALIB_CYCLES)) begin
      cal_cnt_c = cal_cnt + CAL_W'(1);
    end
    calib_c       = (cal_cnt_c == CAL_W'(CALIB_CYCLES));

    ref_cnt_c     = '0;
    if (init_calib_complete) begin
      ref_cnt_c = (ref_cnt == REF_W'(REF_LAST)) ? '0 : ref_cnt + REF_W'(1);
    end
    stall_c       = STALL_EN && init_calib_complete && (ref_cnt_c >= REF_W'(REF_ON));

    app_rdy_c     = init_calib_complete && (cmd_cnt_c != CNT_W'(DEPTH)) && !stall_c;
    app_wdf_rdy_c = init_calib_complete && (wdf_cnt_c != CNT_W'(DEPTH));
    err_c         = err || bad_go_c ||
                    (cmd_push_c && (app_addr[2:0] != 3'b000)) ||
                    (wdf_push_c && !app_wdf_end);
  end

  // Control state: pointers, counts, calibration/refresh counters, flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_wr              <= '0;
      cmd_rd              <= '0;
      wdf_wr              <= '0;
      wdf_rd              <= '0;
      cmd_cnt             <= '0;
      wdf_cnt             <= '0;
      cal_cnt             <= '0;
      ref_cnt             <= '0;
      stall_q             <= 1'b0;
      init_calib_complete <= 1'b0;
      app_rdy             <= 1'b0;
      app_wdf_rdy         <= 1'b0;
      err                 <= 1'b0;
    end else begin
      if (cmd_push_c) cmd_wr <= cmd_wr + PTR_W'(1);
      if (exec_go_c)  cmd_rd <= cmd_rd + PTR_W'(1);
      if (wdf_push_c) wdf_wr <= wdf_wr + PTR_W'(1);
      if (wr_go_c)    wdf_rd <= wdf_rd + PTR_W'(1);
      cmd_cnt             <= cmd_cnt_c;
      wdf_cnt             <= wdf_cnt_c;
      cal_cnt             <= cal_cnt_c;
      ref_cnt             <= ref_cnt_c;
      stall_q             <= stall_c;
      init_calib_complete <= calib_c;
      app_rdy             <= app_rdy_c;
      app_wdf_rdy         <= app_wdf_rdy_c;
      err                 <= err_c;
    end
  end

  // FIFO payload capture
  always_ff @(posedge clk) begin
    if (cmd_push_c) begin
      cmd_q[cmd_wr] <= app_cmd;
      idx_q[cmd_wr] <= app_addr[MEM_AW+2:3];
    end
    if (wdf_push_c) begin
      data_q[wdf_wr] <= app_wdf_data;
      mask_q[wdf_wr] <= app_wdf_mask;
    end
  end

  // Byte-masked RAM write at the write's execute edge
  always_ff @(posedge clk) begin
    if (wr_go_c) begin
      for (int b = 0; b < int'(MASK_W); b++) begin
        if (!mask_q[wdf_rd][b]) begin
          mem[head_idx_c][b*8 +: 8] <= data_q[wdf_rd][b*8 +: 8];
        end
      end
    end
  end

  // Read-return pipeline: RAM read at execute, output after RD_LATENCY more edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RD_LATENCY); i++) begin
        rd_vld_pipe[i] <= 1'b0;
        rd_dat_pipe[i] <= '0;
      end
      app_rd_data       <= '0;
      app_rd_data_valid <= 1'b0;
      app_rd_data_end   <= 1'b0;
    end else begin
      rd_vld_pipe[0] <= rd_go_c;
      rd_dat_pipe[0] <= mem[head_idx_c];
      for (int i = 1; i < int'(RD_LATENCY); i++) begin
        rd_vld_pipe[i] <= rd_vld_pipe[i-1];
        rd_dat_pipe[i] <= rd_dat_pipe[i-1];
      end
      app_rd_data       <= rd_dat_pipe[RD_LATENCY-1];
      app_rd_data_valid <= rd_vld_pipe[RD_LATENCY-1];
      app_rd_data_end   <= rd_vld_pipe[RD_LATENCY-1];
    end
  end

endmodule
